// File: rtl/cnn_frame_streamer.sv
`default_nettype none
// ============================================================================
// cnn_frame_streamer: raster-order frame reader emitting a valid/ready pixel stream
// Optional: CNN_STREAM_RELU_EN clamps negative pixels to zero.  Rev 1.0
// ============================================================================
module cnn_frame_streamer #(
  parameter  int DWIDTH = 32,
  parameter  int HEIGHT = 240,
  parameter  int WIDTH  = 320,
  localparam int WAW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int HAW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              en_r_n,
  output logic [WAW-1:0]    waddr_r,
  output logic [HAW-1:0]    haddr_r,
  input  logic [DWIDTH-1:0] data_r,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done
);

  localparam logic [WAW-1:0] c_WLAST = WAW'(WIDTH - 1);
  localparam logic [HAW-1:0] c_HLAST = HAW'(HEIGHT - 1);
  localparam int             c_EW    = DWIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [WAW-1:0]  r_waddr, w_waddr_nxt;
  logic [HAW-1:0]  r_haddr, w_haddr_nxt;
  logic            r_inflight;
  logic            r_pend_sof, r_pend_eol, r_pend_eof;
  logic [c_EW-1:0] r_fifo [0:1];
  logic            r_wptr, r_rptr;
  logic [1:0]      r_count;

  logic            w_push, w_pop, w_issue;
  logic [2:0]      w_occ;
  logic            w_sof, w_eol, w_eof;
  logic [c_EW-1:0] w_head;
  logic [DWIDTH-1:0] w_pix;

`ifdef CNN_STREAM_RELU_EN
  assign w_pix = data_r[DWIDTH-1] ? '0 : data_r;
`else
  assign w_pix = data_r;
`endif

  assign w_head  = r_fifo[r_rptr];
  assign m_valid = (r_count != 2'd0);
  assign m_data  = m_valid ? w_head[c_EW-1:3] : '0;
  assign m_sof   = m_valid & w_head[2];
  assign m_eol   = m_valid & w_head[1];
  assign m_eof   = m_valid & w_head[0];

  assign w_push = r_inflight;
  assign w_pop  = m_valid & m_ready;
  // Occupancy counts buffered beats plus the read still in the memory pipe.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_READ) && (w_occ < 3'd2);

  assign w_sof = (r_waddr == '0) && (r_haddr == '0);
  assign w_eol = (r_waddr == c_WLAST);
  assign w_eof = w_eol && (r_haddr == c_HLAST);

  assign en_r_n  = ~w_issue;
  assign waddr_r = r_waddr;
  assign haddr_r = r_haddr;
  assign busy    = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_waddr_nxt = r_waddr;
    w_haddr_nxt = r_haddr;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_READ;
      S_READ: begin
        if (w_issue) begin
          if (w_eof) begin
            w_waddr_nxt = '0;
            w_haddr_nxt = '0;
            w_state_nxt = S_DRAIN;
          end else if (w_eol) begin
            w_waddr_nxt = '0;
            w_haddr_nxt = r_haddr + HAW'(1);
          end else begin
            w_waddr_nxt = r_waddr + WAW'(1);
          end
        end
      end
      S_DRAIN: if (w_pop && w_head[0]) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_waddr    <= '0;
      r_haddr    <= '0;
      r_inflight <= 1'b0;
      r_pend_sof <= 1'b0;
      r_pend_eol <= 1'b0;
      r_pend_eof <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_waddr    <= w_waddr_nxt;
      r_haddr    <= w_haddr_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pend_sof <= w_sof;
        r_pend_eol <= w_eol;
        r_pend_eof <= w_eof;
      end
      if (w_push) begin
        r_fifo[r_wptr] <= {w_pix, r_pend_sof, r_pend_eol, r_pend_eof};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: doc/cnn_frame_streamer.md
Name: cnn_frame_streamer

Overview:
- Reader-side counterpart of the frame copy engine: scans a completed HEIGHT x WIDTH frame out of the output memory.
- Walks the frame in raster order and emits the pixels as a valid/ready stream with frame and line markers.
- Sits between the accelerator's output memory read port and the downstream consumer (DMA or next layer).
- Tolerates arbitrary backpressure without losing or duplicating pixels.

Parameters:
- DWIDTH, 32, pixel/memory data width
- HEIGHT, 240, rows per frame
- WIDTH, 320, pixels per row

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; sampled only in IDLE
- en_r_n  out  1  active-low memory read enable
- waddr_r  out  $clog2(WIDTH)  column read address
- haddr_r  out  $clog2(HEIGHT)  row read address
- data_r  in  DWIDTH  memory read data, valid the cycle after en_r_n low
- m_data  out  DWIDTH  stream pixel
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready; beat transfers when m_valid && m_ready
- m_sof  out  1  beat is pixel (0,0)
- m_eol  out  1  beat is last column of a row
- m_eof  out  1  beat is last pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final beat transfers

Behaviour:
- Reset state: en_r_n=1, waddr_r=0, haddr_r=0, m_valid=0, m_data=0, m_sof/m_eol/m_eof=0, busy=0, done=0, state=IDLE, FIFO empty, in-flight flag clear.
- Memory timing: synchronous read with 1-cycle latency. A read is "issued" in any cycle with en_r_n=0; the address is presented in that same cycle.
- Output buffer: 2-entry FIFO holding {data, sof, eol, eof}. The flags are computed from the address at issue and travel with the data.
  - m_data and the flags are driven from the FIFO head; m_valid = FIFO not empty.
  - Head and flags must stay stable while m_valid && !m_ready.
- Credit rule: issue a read only when (FIFO count + in-flight − pop this cycle) < 2. This gives full throughput (1 beat/cycle) when m_ready=1 and guarantees no overflow.
- States:
  - IDLE: en_r_n=1. start=1 -> READ, busy=1 from the next cycle.
  - READ: issue reads per the credit rule.
    - After each issue, waddr_r increments. At WIDTH−1 it wraps to 0 and haddr_r increments.
    - Issuing (HEIGHT−1, WIDTH−1) -> DRAIN, and both addresses return to 0.
  - DRAIN: en_r_n=1. When the eof beat transfers -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- start is ignored outside IDLE.
- Latency with m_ready=1:
  - start in cycle 0 -> first read in cycle 1 -> data_r in cycle 2 -> m_valid=1 with sof in cycle 3.
  - A frame of N=HEIGHT*WIDTH pixels completes with done in cycle N+3.
- Boundaries:
  - Row wrap and frame end happen in the same address update without a bubble.
  - A single-pixel frame (HEIGHT=WIDTH=1) asserts sof, eol and eof on the same beat.
  - m_ready low indefinitely: at most 2 pixels are buffered, en_r_n stays 1, nothing is lost.
- Reset mid-frame: all state returns to reset values on the next edge. Any in-flight read data is discarded. The next start streams from (0,0).

Optional Feature:
- Macro: CNN_STREAM_RELU_EN.
- Defined: data_r is treated as two's complement, and negative values are written into the FIFO as 0. There is no latency or throughput change.
- Undefined: data_r passes through unchanged.

Test Plan:
- Full-rate frame: HEIGHT=3, WIDTH=4, memory model returns {haddr,waddr}, m_ready=1, start in cycle 0 -> 12 consecutive beats 0x00..0x23 in cycles 3–14, done=1 in cycle 15, busy high in cycles 1–14.
- Backpressure: m_ready low for 5 cycles after beat 2, then toggling every cycle -> exactly 12 beats in order with no duplicates, m_data stable while stalled, never more than 2 reads outstanding.
- Markers: full frame -> m_sof only on beat (0,0); m_eol on beats (r,3) for r=0..2; m_eof only on beat (2,3), together with m_eol.
- Reset mid-frame: reset_n low for 1 cycle after beat 5 -> all outputs at reset values next cycle; a new start yields a full 12-beat frame from (0,0) with no stale data.
- Start handling: start pulsed in cycles 4 and 9 during a frame -> ignored, a single done pulse; start in the cycle after done -> a new frame begins.
- ReLU (macro defined): memory returns 0xFFFFFFF0 at (1,1) and 0x00000007 at (1,2) -> beats show 0x00000000 and 0x00000007. With the macro undefined, 0xFFFFFFF0 passes through unchanged.
